// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 width codes, the
// load/store FSM encoding and a funct3 legality helper.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } mau_state_t;

  // Encodings with no RV32I load/store meaning.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load data extraction: selects the addressed byte/half lane of
// a bus word and sign- or zero-extends it according to funct3.
module load_extender
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{lane, 3'b000} +: 8];
  // Halves always use the addr[1] lane, so a misaligned half reads the aligned one.
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: assign a default first so every path drives result and no latch is inferred.
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      F3_W:    result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one data-bus req/ack transaction per request, with load
// extension, error responses and a bus timeout. Define MEM_MISALIGN_TRAP_EN
// to turn misaligned halfword/word accesses into error responses.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  mau_state_t       state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       lane_q;
  logic [2:0]       f3_q;
  logic [31:0]      ext_data;
  logic             bad_op, misaligned, no_op, tmo_hit;
  logic [3:0]       be_new;
  logic [31:0]      wdata_new;

  load_extender u_load_extender (
    .rdata  (dbus_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .result (ext_data)
  );

  // Request decode and lane generation from the un-latched inputs.
  always_comb begin
    bad_op = f3_illegal(funct3) | (mem_write & funct3[2]) | (mem_read & mem_write);
    no_op  = ~mem_read & ~mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    be_new    = 4'b1111;
    wdata_new = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
    endcase
  end

  // The last counted BUS cycle; an ack in that same cycle still completes normally.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = (bad_op | misaligned | no_op) ? S_RESP : S_BUS;
      S_BUS:  if (dbus_ack || tmo_hit) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    dbus_req  = (state == S_BUS);
    rsp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      lane_q     <= '0;
      f3_q       <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      tmo_cnt <= (state == S_BUS) ? tmo_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (req_valid) begin
          dbus_we    <= mem_write;
          dbus_addr  <= {addr[31:2], 2'b00};
          dbus_be    <= be_new;
          dbus_wdata <= wdata_new;
          lane_q     <= addr[1:0];
          f3_q       <= funct3;
          rsp_rdata  <= '0;
          rsp_err    <= bad_op | misaligned;
        end
        S_BUS: begin
          if (dbus_ack) begin
            if (!dbus_we) rsp_rdata <= ext_data;
          end else if (tmo_hit) begin
            rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
